// File: rtl/fmul_norm_round_pipe.sv
// fmul_norm_round_pipe
//   Last stage of the pipelined FP multiplier. Merges the two partial-product
//   halves, normalises the product, forms the biased exponent, rounds
//   (truncate or round-to-nearest-even) and raises overflow / underflow /
//   inexact. Two register stages with valid/ready flow control on both sides.
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready         input handshake
//   in_sign                     result sign from upstream
//   a_exp, b_exp                biased operand exponents
//   special, special_exp/frac   pre-resolved Inf/NaN/zero result
//   c_hi, c_lo                  partial products, P = (c_hi<<SPLIT)+c_lo
//   out_valid / out_ready       output handshake
//   out_sign/exp/frac           result
//   out_ovf/unf/inexact         status flags
//   busy                        either stage holds a beat
module fmul_norm_round_pipe #(
  parameter int EXP_W      = 8,
  parameter int FRAC_W     = 23,
  parameter int BIAS       = 2**(EXP_W-1)-1,
  parameter int SPLIT      = 12,
  parameter int ROUND_MODE = 1,
  localparam int PW        = 2*(FRAC_W+1),
  localparam int CW        = PW-SPLIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic              special,
  input  logic [EXP_W-1:0]  special_exp,
  input  logic [FRAC_W-1:0] special_frac,
  input  logic [CW-1:0]     c_hi,
  input  logic [CW-1:0]     c_lo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_inexact,
  output logic              busy
);

  localparam int EW = EXP_W+2;
  localparam logic signed [EW-1:0] E_MAX  = EW'((2**EXP_W)-1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [EW-1:0]        E_BIAS = EW'(BIAS);

  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return (ROUND_MODE != 0) && guard && (sticky || lsb);
  endfunction

  // Control
  logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic s1_ready, s2_ready, ld1, ld2;

  // Stage 1 data
  logic [PW-1:0]          prod;
  logic [PW-2:0]          field;
  logic [FRAC_W-1:0]      mant_p1_d, mant_p1_q;
  logic                   guard_p1_d, guard_p1_q, sticky_p1_d, sticky_p1_q;
  logic                   nz_p1_d, nz_p1_q;
  logic signed [EW-1:0]   e_p1_d, e_p1_q;
  logic                   sign_p1_q, special_p1_q;
  logic [EXP_W-1:0]       sexp_p1_q;
  logic [FRAC_W-1:0]      sfrac_p1_q;

  // Stage 2 data
  logic                   inc;
  logic [FRAC_W:0]        sum;
  logic signed [EW-1:0]   e_r;
  logic                   sign_p2_q, sign_p2_d;
  logic [EXP_W-1:0]       exp_p2_q, exp_p2_d;
  logic [FRAC_W-1:0]      frac_p2_q, frac_p2_d;
  logic                   ovf_p2_q, ovf_p2_d, unf_p2_q, unf_p2_d, inx_p2_q, inx_p2_d;

  always_comb begin
    s2_ready = !vld_p2_q || out_ready;
    s1_ready = !vld_p1_q || s2_ready;
    ld1      = in_valid && s1_ready;
    ld2      = vld_p1_q && s2_ready;
    vld_p1_d = s1_ready ? in_valid : vld_p1_q;
    vld_p2_d = s2_ready ? vld_p1_q : vld_p2_q;
  end

  // ---- stage 0 -> 1: merge partial products, normalise, form exponent ----
  always_comb begin
    prod  = ({{SPLIT{1'b0}}, c_hi} << SPLIT) + {{SPLIT{1'b0}}, c_lo};
    // Bits below the hidden one; shifting by one when the MSB is clear
    // moves every field one position lower.
    field = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    mant_p1_d   = field[PW-2 -: FRAC_W];
    guard_p1_d  = field[PW-2-FRAC_W];
    sticky_p1_d = |field[PW-3-FRAC_W:0];
    nz_p1_d     = |prod;
    e_p1_d      = {2'b00, a_exp} + {2'b00, b_exp} + {{(EW-1){1'b0}}, prod[PW-1]} - E_BIAS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld1) begin
      mant_p1_q    <= mant_p1_d;
      guard_p1_q   <= guard_p1_d;
      sticky_p1_q  <= sticky_p1_d;
      nz_p1_q      <= nz_p1_d;
      e_p1_q       <= e_p1_d;
      sign_p1_q    <= in_sign;
      special_p1_q <= special;
      sexp_p1_q    <= special_exp;
      sfrac_p1_q   <= special_frac;
    end
  end

  // ---- stage 1 -> 2: special / flush / overflow / round ----
  always_comb begin
    inc      = rne_inc(guard_p1_q, sticky_p1_q, mant_p1_q[0]);
    sum      = {1'b0, mant_p1_q} + {{FRAC_W{1'b0}}, inc};
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    e_r      = e_p1_q + {{(EW-1){1'b0}}, sum[FRAC_W]};
    sign_p2_d = sign_p1_q;
    exp_p2_d  = '0;
    frac_p2_d = '0;
    ovf_p2_d  = 1'b0;
    unf_p2_d  = 1'b0;
    inx_p2_d  = 1'b0;
    if (special_p1_q) begin
      exp_p2_d  = sexp_p1_q;
      frac_p2_d = sfrac_p1_q;
    end else if (e_p1_q <= E_ZERO) begin
      unf_p2_d = 1'b1;
      inx_p2_d = nz_p1_q;
    end else if (e_p1_q >= E_MAX || e_r == E_MAX) begin
      exp_p2_d = '1;
      ovf_p2_d = 1'b1;
      inx_p2_d = 1'b1;
    end else begin
      exp_p2_d  = e_r[EXP_W-1:0];
      frac_p2_d = sum[FRAC_W-1:0];
      inx_p2_d  = guard_p1_q || sticky_p1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_p2_q <= 1'b0;
      exp_p2_q  <= '0;
      frac_p2_q <= '0;
      ovf_p2_q  <= 1'b0;
      unf_p2_q  <= 1'b0;
      inx_p2_q  <= 1'b0;
    end else if (ld2) begin
      sign_p2_q <= sign_p2_d;
      exp_p2_q  <= exp_p2_d;
      frac_p2_q <= frac_p2_d;
      ovf_p2_q  <= ovf_p2_d;
      unf_p2_q  <= unf_p2_d;
      inx_p2_q  <= inx_p2_d;
    end
  end

  assign in_ready    = s1_ready;
  assign out_valid   = vld_p2_q;
  assign out_sign    = sign_p2_q;
  assign out_exp     = exp_p2_q;
  assign out_frac    = frac_p2_q;
  assign out_ovf     = ovf_p2_q;
  assign out_unf     = unf_p2_q;
  assign out_inexact = inx_p2_q;
  assign busy        = vld_p1_q || vld_p2_q;

endmodule

// File: tb/tb_fmul_norm_round_pipe.sv
// Testbench for fmul_norm_round_pipe: a round-to-nearest-even instance and a
// truncating instance share the same stimulus; expected results are queued
// on accept and compared when each beat leaves the pipe.
module tb_fmul_norm_round_pipe;

  typedef logic [34:0] res_t; // {sign, exp[7:0], frac[22:0], ovf, unf, inexact}
  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sp;
    logic [7:0]  se;
    logic [22:0] sf;
    logic [35:0] ch;
    logic [35:0] cl;
    res_t        er;
  } vec_t;
  typedef struct {
    res_t rne;
    res_t trn;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sign, special, out_ready;
  logic [7:0]  a_exp, b_exp, special_exp;
  logic [22:0] special_frac;
  logic [35:0] c_hi, c_lo;

  logic        r_in_ready, r_valid, r_sign, r_ovf, r_unf, r_inx, r_busy;
  logic [7:0]  r_exp;
  logic [22:0] r_frac;
  logic        t_in_ready, t_valid, t_sign, t_ovf, t_unf, t_inx, t_busy;
  logic [7:0]  t_exp;
  logic [22:0] t_frac;
  res_t        rne_out, trn_out;

  int   checks = 0;
  int   errors = 0;
  sb_t  q[$];
  sb_t  popped;
  logic stall_prev = 1'b0;
  logic saw_full   = 1'b0;
  res_t held;
  vec_t tbl[12];

  assign rne_out = {r_sign, r_exp, r_frac, r_ovf, r_unf, r_inx};
  assign trn_out = {t_sign, t_exp, t_frac, t_ovf, t_unf, t_inx};

  fmul_norm_round_pipe u_rne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_sign(in_sign), .a_exp(a_exp), .b_exp(b_exp), .special(special),
    .special_exp(special_exp), .special_frac(special_frac), .c_hi(c_hi), .c_lo(c_lo),
    .out_valid(r_valid), .out_ready(out_ready), .out_sign(r_sign), .out_exp(r_exp),
    .out_frac(r_frac), .out_ovf(r_ovf), .out_unf(r_unf), .out_inexact(r_inx), .busy(r_busy)
  );

  fmul_norm_round_pipe #(.ROUND_MODE(0)) u_trn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_sign(in_sign), .a_exp(a_exp), .b_exp(b_exp), .special(special),
    .special_exp(special_exp), .special_frac(special_frac), .c_hi(c_hi), .c_lo(c_lo),
    .out_valid(t_valid), .out_ready(out_ready), .out_sign(t_sign), .out_exp(t_exp),
    .out_frac(t_frac), .out_ovf(t_ovf), .out_unf(t_unf), .out_inexact(t_inx), .busy(t_busy)
  );

  always #5 clk = ~clk;

  // Reference: normalise so the hidden bit sits at bit 47, then round as integers.
  function automatic res_t model(input vec_t v, input int mode);
    logic [47:0] p, sh;
    logic [22:0] m;
    logic        g, s;
    int          e, val;
    if (v.sp) return {v.sgn, v.se, v.sf, 3'b000};
    p  = ({12'h0, v.ch} << 12) + {12'h0, v.cl};
    sh = p[47] ? p : (p << 1);
    m  = sh[46:24];
    g  = sh[23];
    s  = |sh[22:0];
    e  = int'(a_of(v)) + int'(v.b) + int'(p[47]) - 127;
    if (e <= 0)   return {v.sgn, 8'h00, 23'h0, 2'b01, (p != 48'h0)};
    if (e >= 255) return {v.sgn, 8'hFF, 23'h0, 3'b101};
    val = int'(m) + ((mode == 1 && g && (s || m[0])) ? 1 : 0);
    if (val == (1 << 23)) begin
      val = 0;
      e   = e + 1;
    end
    if (e == 255) return {v.sgn, 8'hFF, 23'h0, 3'b101};
    return {v.sgn, 8'(e), 23'(val), 2'b00, (g | s)};
  endfunction

  function automatic logic [7:0] a_of(input vec_t v);
    return v.a;
  endfunction

  function automatic vec_t mk(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                              input logic sp, input logic [7:0] se, input logic [22:0] sf,
                              input logic [47:0] p, input res_t er);
    vec_t v;
    v.sgn = sgn; v.a = a; v.b = b; v.sp = sp; v.se = se; v.sf = sf;
    v.ch  = p[47:12];
    v.cl  = {24'h0, p[11:0]};
    v.er  = er;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.sgn = 1'($urandom_range(0, 1));
    v.a   = 8'($urandom_range(0, 255));
    v.b   = 8'($urandom_range(0, 255));
    v.sp  = ($urandom_range(0, 7) == 0);
    v.se  = 8'($urandom);
    v.sf  = 23'($urandom);
    v.ch  = 36'({$urandom, $urandom});
    v.cl  = 36'({$urandom, $urandom});
    v.er  = model(v, 1);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Called aligned to posedge+1; returns aligned to posedge+1 after the accept edge.
  task automatic send(input vec_t v);
    int  n;
    sb_t e;
    n = 0;
    in_sign = v.sgn; a_exp = v.a; b_exp = v.b; special = v.sp;
    special_exp = v.se; special_frac = v.sf; c_hi = v.ch; c_lo = v.cl;
    in_valid = 1'b1;
    e.rne = v.er;
    e.trn = model(v, 0);
    forever begin
      @(negedge clk);
      if (r_in_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      n++;
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", n);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, expected 0", q.size());
    end
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 35'(r_valid), 35'd1);
        chk("hold_data", rne_out, held);
      end
      if (r_valid && out_ready) begin
        chk("trn_valid", 35'(t_valid), 35'd1);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got %h expected no beat", rne_out);
        end else begin
          popped = q.pop_front();
          chk("rne_result", rne_out, popped.rne);
          chk("trn_result", trn_out, popped.trn);
        end
      end
      stall_prev = r_valid && !out_ready;
      held       = rne_out;
      if (!r_in_ready) saw_full = 1'b1;
    end
  end

  initial begin
    tbl[0]  = mk(1'b0, 8'd127, 8'd127, 1'b0, 8'h0, 23'h0, 48'h900000000000, {1'b0, 8'd128, 23'h100000, 3'b000});
    tbl[1]  = mk(1'b0, 8'd127, 8'd127, 1'b0, 8'h0, 23'h0, 48'h400000400000, {1'b0, 8'd127, 23'h000000, 3'b001});
    tbl[2]  = mk(1'b0, 8'd127, 8'd127, 1'b0, 8'h0, 23'h0, 48'h400000C00000, {1'b0, 8'd127, 23'h000002, 3'b001});
    tbl[3]  = mk(1'b0, 8'd254, 8'd254, 1'b0, 8'h0, 23'h0, 48'h400000000000, {1'b0, 8'hFF, 23'h0, 3'b101});
    tbl[4]  = mk(1'b1, 8'd127, 8'd254, 1'b0, 8'h0, 23'h0, 48'h7FFFFFC00000, {1'b1, 8'hFF, 23'h0, 3'b101});
    tbl[5]  = mk(1'b1, 8'd1,   8'd1,   1'b0, 8'h0, 23'h0, 48'h400000000000, {1'b1, 8'h00, 23'h0, 3'b011});
    tbl[6]  = mk(1'b1, 8'd0,   8'd0,   1'b1, 8'hFF, 23'h400000, 48'h0,      {1'b1, 8'hFF, 23'h400000, 3'b000});
    tbl[7]  = mk(1'b0, 8'd130, 8'd100, 1'b0, 8'h0, 23'h0, 48'h400000000000, {1'b0, 8'd103, 23'h0, 3'b000});
    tbl[8]  = mk(1'b0, 8'd127, 8'd127, 1'b0, 8'h0, 23'h0, 48'hC00000C00001, {1'b0, 8'd128, 23'h400001, 3'b001});
    tbl[9]  = mk(1'b0, 8'd64,  8'd64,  1'b0, 8'h0, 23'h0, 48'h400000000000, {1'b0, 8'd1, 23'h0, 3'b000});
    tbl[10] = mk(1'b0, 8'd63,  8'd64,  1'b0, 8'h0, 23'h0, 48'h400000000000, {1'b0, 8'd0, 23'h0, 3'b011});
    tbl[11] = mk(1'b0, 8'd127, 8'd254, 1'b0, 8'h0, 23'h0, 48'h400000000000, {1'b0, 8'hFE, 23'h0, 3'b000});

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; a_exp = '0; b_exp = '0;
    special = 1'b0; special_exp = '0; special_frac = '0; c_hi = '0; c_lo = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 35'({r_valid, t_valid}), 35'd0);
    chk("rst_in_ready", 35'({r_in_ready, t_in_ready}), 35'd3);
    chk("rst_busy", 35'({r_busy, t_busy}), 35'd0);
    chk("rst_data", rne_out, 35'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accepted on edge E0, visible after E1.
    send(tbl[0]);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_1cyc_valid", 35'(r_valid), 35'd0);
    chk("lat_busy", 35'(r_busy), 35'd1);
    @(negedge clk);
    chk("lat_2cyc_valid", 35'(r_valid), 35'd1);
    @(posedge clk); #1;
    drain();

    // Directed vectors, back to back.
    for (int i = 0; i < 12; i++) send(tbl[i]);
    in_valid = 1'b0;
    drain();

    // Random vectors under random backpressure.
    fork
      begin
        for (int i = 0; i < 60; i++) send(rand_vec());
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 120; k++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Five-beat stream with out_ready low for cycles 3-6.
    saw_full  = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) send(tbl[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_dropped", 35'(saw_full), 35'd1);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(tbl[2]);
    send(tbl[3]);
    in_valid = 1'b0;
    chk("pre_rst_valid", 35'(r_valid), 35'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 35'({r_valid, t_valid}), 35'd0);
    chk("mid_rst_ready_busy", 35'({r_in_ready, r_busy}), 35'b10);
    chk("mid_rst_data", rne_out, 35'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(tbl[7]);
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
